// File: rtl/hue_wheel_fader.sv
// RGB hue-wheel fader: six-segment colour wheel driven by a shared ramp,
// with run/freeze, reverse traversal, global brightness and pin polarity.
module hue_wheel_fader #(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_CYCLES  = 20000,
    parameter int STEP_SIZE    = 12,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       reverse,
    input  logic [7:0] brightness,
    output logic [2:0] rgb_out,
    output logic [2:0] segment,
    output logic       wrap
);

    localparam int PW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int DW = $clog2(PWM_INTERVAL + 1);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic OFF_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic ON_LVL  = ~OFF_LVL;

    typedef enum logic [1:0] {
        ROLE_LOW  = 2'd0,
        ROLE_HIGH = 2'd1,
        ROLE_INC  = 2'd2,
        ROLE_DEC  = 2'd3
    } role_t;

    // Channel roles packed as {R, G, B}, two bits each.
    function automatic logic [5:0] seg_roles(input logic [2:0] seg);
        case (seg)
            3'd0:    seg_roles = {ROLE_HIGH, ROLE_INC,  ROLE_LOW};
            3'd1:    seg_roles = {ROLE_DEC,  ROLE_HIGH, ROLE_LOW};
            3'd2:    seg_roles = {ROLE_LOW,  ROLE_HIGH, ROLE_INC};
            3'd3:    seg_roles = {ROLE_LOW,  ROLE_DEC,  ROLE_HIGH};
            3'd4:    seg_roles = {ROLE_INC,  ROLE_LOW,  ROLE_HIGH};
            3'd5:    seg_roles = {ROLE_HIGH, ROLE_LOW,  ROLE_DEC};
            default: seg_roles = {ROLE_LOW,  ROLE_LOW,  ROLE_LOW};
        endcase
    endfunction

    function automatic logic [DW-1:0] role_duty(input logic [1:0] role, input logic [DW-1:0] e);
        case (role)
            ROLE_HIGH: role_duty = DW'(PWM_INTERVAL);
            ROLE_LOW:  role_duty = {DW{1'b0}};
            ROLE_INC:  role_duty = e;
            ROLE_DEC:  role_duty = DW'(PWM_INTERVAL) - e;
            default:   role_duty = {DW{1'b0}};
        endcase
    endfunction

    logic [SW-1:0] r_presc;
    logic [PW-1:0] r_ramp;
    logic [2:0]    r_seg;
    logic          r_rev;
    logic          r_wrap;
    logic [PW-1:0] r_pc;
    logic [DW-1:0] r_duty [3];
    logic [2:0]    r_rgb;

    logic          w_step;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_ramp_step;
    logic [PW-1:0] w_ramp_next;
    logic          w_adv;
    logic [2:0]    w_seg_next;
    logic          w_wrap_next;
    logic [PW-1:0] w_eff;
    logic [5:0]    w_roles;
    logic [DW-1:0] w_raw    [3];
    logic [DW+7:0] w_prod   [3];
    logic [DW-1:0] w_scaled [3];

    // Next ramp/segment: step first, then mirror the ramp on a direction change.
    always_comb begin
        w_step      = run && (r_presc == SW'(STEP_CYCLES - 1));
        w_sum       = {1'b0, r_ramp} + (PW+1)'(STEP_SIZE);
        w_adv       = 1'b0;
        w_ramp_step = r_ramp;
        w_seg_next  = r_seg;
        w_wrap_next = 1'b0;
        if (w_step) begin
            if (w_sum >= (PW+1)'(PWM_INTERVAL)) begin
                w_adv       = 1'b1;
                w_ramp_step = {PW{1'b0}};
            end else begin
                w_ramp_step = PW'(w_sum);
            end
        end else begin
            w_ramp_step = r_ramp;
        end
        if (w_adv) begin
            if (reverse) begin
                w_seg_next  = (r_seg == 3'd0) ? 3'd5 : r_seg - 3'd1;
                w_wrap_next = (r_seg == 3'd0);
            end else begin
                w_seg_next  = (r_seg == 3'd5) ? 3'd0 : r_seg + 3'd1;
                w_wrap_next = (r_seg == 3'd5);
            end
        end else begin
            w_seg_next  = r_seg;
            w_wrap_next = 1'b0;
        end
        if (reverse != r_rev) begin
            w_ramp_next = PW'(PWM_INTERVAL - 1) - w_ramp_step;
        end else begin
            w_ramp_next = w_ramp_step;
        end
    end

    // Scaled per-channel duties from the current segment and effective ramp.
    always_comb begin
        w_eff   = r_rev ? (PW'(PWM_INTERVAL - 1) - r_ramp) : r_ramp;
        w_roles = seg_roles(r_seg);
        for (int i = 0; i < 3; i++) begin
            w_raw[i]    = role_duty(w_roles[2*i +: 2], DW'(w_eff));
            w_prod[i]   = (DW+8)'(w_raw[i]) * (DW+8)'({1'b0, brightness} + 9'd1);
            w_scaled[i] = DW'(w_prod[i] >> 8);
        end
    end

    // Prescaler, ramp, segment and revolution marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= {SW{1'b0}};
            r_ramp  <= {PW{1'b0}};
            r_seg   <= 3'd0;
            r_rev   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            if (run) begin
                r_presc <= w_step ? {SW{1'b0}} : r_presc + SW'(1);
            end
            r_ramp <= w_ramp_next;
            r_seg  <= w_seg_next;
            r_rev  <= reverse;
            r_wrap <= w_wrap_next;
        end
    end

    // PWM counter, end-of-period duty latch and registered pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= {PW{1'b0}};
            r_rgb <= {3{OFF_LVL}};
            for (int i = 0; i < 3; i++) begin
                r_duty[i] <= {DW{1'b0}};
            end
        end else begin
            r_pc <= (r_pc == PW'(PWM_INTERVAL - 1)) ? {PW{1'b0}} : r_pc + PW'(1);
            for (int i = 0; i < 3; i++) begin
                if (r_pc == PW'(PWM_INTERVAL - 1)) begin
                    r_duty[i] <= w_scaled[i];
                end
                r_rgb[i] <= (DW'(r_pc) < r_duty[i]) ? ON_LVL : OFF_LVL;
            end
        end
    end

    assign rgb_out = r_rgb;
    assign segment = r_seg;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_hue_wheel_fader.sv
// Randomised bench for hue_wheel_fader against a cycle-level behavioural model
// of the colour wheel, plus fixed reset and revolution checkpoints.
module tb_hue_wheel_fader;

    localparam int P  = 8;
    localparam int SC = 4;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       reverse;
    logic [7:0] brightness;
    logic [2:0] rgb_out;
    logic [2:0] segment;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    int m_presc, m_r, m_seg, m_rev, m_pc, m_pins, m_wrap;
    int m_duty [3];
    string roles [6] = '{"HIL", "DHL", "LHI", "LDH", "ILH", "HLD"};

    hue_wheel_fader #(
        .PWM_INTERVAL(P),
        .STEP_CYCLES (SC),
        .STEP_SIZE   (SS),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .reverse   (reverse),
        .brightness(brightness),
        .rgb_out   (rgb_out),
        .segment   (segment),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0; m_r = 0; m_seg = 0; m_rev = 0; m_pc = 0;
        m_pins = 7; m_wrap = 0;
        for (int c = 0; c < 3; c++) m_duty[c] = 0;
    endtask

    // Duty of channel c (0=R,1=G,2=B) from the wheel position and brightness.
    function automatic int model_duty(input int c);
        string rs;
        byte   ch;
        int    e, raw;
        rs  = roles[m_seg];
        ch  = rs.getc(c);
        e   = m_rev ? (P - 1 - m_r) : m_r;
        raw = (ch == "H") ? P : (ch == "I") ? e : (ch == "D") ? (P - e) : 0;
        return (raw * (int'(brightness) + 1)) / 256;
    endfunction

    task automatic model_step();
        bit step;
        int old_seg;
        m_pins = 0;
        for (int c = 0; c < 3; c++)
            if (!(m_pc < m_duty[c])) m_pins |= (1 << (2 - c));
        if (m_pc == P - 1)
            for (int c = 0; c < 3; c++) m_duty[c] = model_duty(c);
        m_pc = (m_pc + 1) % P;
        step = run && (m_presc == SC - 1);
        if (run) m_presc = (m_presc + 1) % SC;
        m_wrap = 0;
        if (step) begin
            if (m_r + SS >= P) begin
                m_r = 0;
                old_seg = m_seg;
                m_seg = reverse ? (m_seg + 5) % 6 : (m_seg + 1) % 6;
                m_wrap = (!reverse && old_seg == 5) || (reverse && old_seg == 0);
            end else begin
                m_r = m_r + SS;
            end
        end
        if (int'(reverse) != m_rev) begin
            m_r   = P - 1 - m_r;
            m_rev = int'(reverse);
        end
    endtask

    task automatic compare_all();
        check_eq("rgb_out", int'(rgb_out), m_pins);
        check_eq("segment", int'(segment), m_seg);
        check_eq("wrap", int'(wrap), m_wrap);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_rgb"}, int'(rgb_out), 7);
        check_eq({tag, "_seg"}, int'(segment), 0);
        check_eq({tag, "_wrap"}, int'(wrap), 0);
        model_reset();
    endtask

    initial begin
        int rst_hold;
        bit in_reset;
        rst_n = 1'b0; run = 1'b0; reverse = 1'b0; brightness = 8'd255;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_rgb", int'(rgb_out), 7);
        check_eq("reset_seg", int'(segment), 0);
        check_eq("reset_wrap", int'(wrap), 0);

        // Frozen hue: first period dark, then red fully on.
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_eq("frozen_rgb", int'(rgb_out), (k <= 8) ? 7 : 3);
        end

        // One full forward revolution from reset.
        async_reset_check("rst_mid");
        tick();
        tick();
        run   = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 97; k++) begin
            tick();
            if (k == 16) check_eq("seg_at_16", int'(segment), 1);
            if (k == 95) check_eq("seg_at_95", int'(segment), 5);
            if (k == 96) begin
                check_eq("seg_at_96", int'(segment), 0);
                check_eq("wrap_at_96", int'(wrap), 1);
            end
            if (k == 97) check_eq("wrap_at_97", int'(wrap), 0);
        end

        // Randomised run/reverse/brightness with occasional async resets.
        in_reset = 1'b0;
        rst_hold = 0;
        for (int i = 0; i < 5000; i++) begin
            if (in_reset) begin
                if (rst_hold == 0) begin
                    rst_n    = 1'b1;
                    in_reset = 1'b0;
                end else begin
                    rst_hold--;
                end
            end else if ($urandom_range(0, 799) == 0) begin
                async_reset_check("rst_rand");
                rst_hold = 2;
                in_reset = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) run = ~run;
            if ($urandom_range(0, 119) == 0) reverse = ~reverse;
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0:       brightness = 8'd0;
                    1:       brightness = 8'd255;
                    2:       brightness = 8'd127;
                    default: brightness = 8'($urandom_range(0, 255));
                endcase
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
